// File: rtl/hstate_packer.sv
// hstate_packer: packs serial 1-bit sampled hidden states LSB-first into
// WORD_W-bit words, queues them in a small FIFO and hands them back to the
// RBM core over valid/ready. Tracks one pass of NUM_HIDDEN states at a time,
// flags dropped or unexpected data and pulses pass_done when the pass drains.
module hstate_packer #(
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_HIDDEN = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              pass_start,
    input  logic              state_in,
    input  logic              state_in_en,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic              overflow,
    output logic              pass_done
);

    localparam int BW = $clog2(WORD_W);
    localparam int SW = $clog2(NUM_HIDDEN + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [BW-1:0] BIT_LAST   = BW'(WORD_W - 1);
    localparam logic [SW-1:0] STATE_LAST = SW'(NUM_HIDDEN - 1);
    localparam logic [CW-1:0] FIFO_FULL  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_DRAIN   = 2'b10
    } state_e;

    // Control state
    state_e            state_q, state_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [SW-1:0]     state_cnt_q, state_cnt_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic              overflow_q, overflow_d;
    logic              pass_done_q, pass_done_d;

    // Output FIFO
    logic [WORD_W-1:0]     mem_q [FIFO_DEPTH];
    logic [WORD_W-1:0]     mem_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] last_q, last_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;

    // Registered head-of-FIFO view
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;

    // Per-cycle decode
    logic              accept_s;
    logic              stray_s;
    logic              final_s;
    logic              push_s;
    logic              push_ok_s;
    logic              pop_s;
    logic              full_s;
    logic [WORD_W-1:0] word_s;

    // Decode acceptance, word completion and FIFO handshake for this cycle
    always_comb begin
        accept_s  = en & state_in_en & (state_q == ST_COLLECT);
        stray_s   = en & state_in_en & (state_q != ST_COLLECT);
        final_s   = accept_s & (state_cnt_q == STATE_LAST);
        push_s    = accept_s & ((bit_cnt_q == BIT_LAST) | (state_cnt_q == STATE_LAST));
        full_s    = (count_q == FIFO_FULL);
        pop_s     = (count_q != {CW{1'b0}}) & out_ready;
        // A push into a full FIFO still lands when the head leaves the same cycle
        push_ok_s = push_s & (~full_s | pop_s);
        // Word as it would look with the current bit merged in; upper bits stay 0
        word_s            = shift_q;
        word_s[bit_cnt_q] = state_in;
    end

    // Next-state for packing counters, FIFO storage, sticky overflow and head view
    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        state_cnt_d = state_cnt_q;
        mem_d       = mem_q;
        last_d      = last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;

        if (pass_start) begin
            shift_d     = {WORD_W{1'b0}};
            bit_cnt_d   = {BW{1'b0}};
            state_cnt_d = {SW{1'b0}};
            last_d      = {FIFO_DEPTH{1'b0}};
            wr_ptr_d    = {PW{1'b0}};
            rd_ptr_d    = {PW{1'b0}};
            count_d     = {CW{1'b0}};
            overflow_d  = 1'b0;
        end else begin
            if (accept_s) begin
                state_cnt_d = state_cnt_q + 1'b1;
                if (push_s) begin
                    shift_d   = {WORD_W{1'b0}};
                    bit_cnt_d = {BW{1'b0}};
                end else begin
                    shift_d   = word_s;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end else begin
                state_cnt_d = state_cnt_q;
            end

            if (push_ok_s) begin
                mem_d[wr_ptr_q]  = word_s;
                last_d[wr_ptr_q] = final_s;
                wr_ptr_d         = wr_ptr_q + 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end

            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end

            case ({push_ok_s, pop_s})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase

            // Dropped word or a bit arriving outside the collect window
            if ((push_s & full_s & ~pop_s) | stray_s) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end
        end

        out_valid_d = (count_d != {CW{1'b0}});
        out_data_d  = out_valid_d ? mem_d[rd_ptr_d] : {WORD_W{1'b0}};
        out_last_d  = out_valid_d & last_d[rd_ptr_d];
    end

    // Pass sequencing: collect NUM_HIDDEN bits, drain the FIFO, pulse pass_done
    always_comb begin
        state_d     = state_q;
        pass_done_d = 1'b0;
        if (pass_start) begin
            state_d = ST_COLLECT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_COLLECT: begin
                    if (final_s) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end
                ST_DRAIN: begin
                    if (count_d == {CW{1'b0}}) begin
                        state_d     = ST_IDLE;
                        pass_done_d = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State register bank with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= {BW{1'b0}};
            state_cnt_q <= {SW{1'b0}};
            shift_q     <= {WORD_W{1'b0}};
            overflow_q  <= 1'b0;
            pass_done_q <= 1'b0;
            mem_q       <= '{default: {WORD_W{1'b0}}};
            last_q      <= {FIFO_DEPTH{1'b0}};
            wr_ptr_q    <= {PW{1'b0}};
            rd_ptr_q    <= {PW{1'b0}};
            count_q     <= {CW{1'b0}};
            out_data_q  <= {WORD_W{1'b0}};
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            state_cnt_q <= state_cnt_d;
            shift_q     <= shift_d;
            overflow_q  <= overflow_d;
            pass_done_q <= pass_done_d;
            mem_q       <= mem_d;
            last_q      <= last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign overflow  = overflow_q;
    assign pass_done = pass_done_q;

endmodule
